// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit seven-segment display between three requesters: round-robin
// ownership with a minimum hold, a blank frame on every hand-over, and the digit scan.
module seg_display_scheduler #(
  parameter int SCAN_DIV = 65536,
  parameter int MIN_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [3:0]  an,
  output logic [3:0]  nibble,
  output logic        blank
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    HOLD_MAX   = 8'(MIN_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc;
  logic [3:0]      an_q;
  logic [15:0]     shown;
  logic [7:0]      hold_cnt;
  logic [1:0]      owner;
  logic [1:0]      pick;
  logic [2:0]      own_oh;
  logic [15:0]     own_data;
  logic            scan_tick, frame_tick;
  logic            any_req, owner_req, other_req;
  logic            take;

  // ---------------------------------------------------------------- digit scan
  assign scan_tick  = (presc == PRESC_LAST);
  assign frame_tick = scan_tick && (an_q == 4'b0111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      an_q  <= 4'b1110;
    end else begin
      presc <= scan_tick ? '0 : presc + PW'(1);
      if (scan_tick) an_q <= {an_q[2:0], an_q[3]};
    end
  end

  assign an = an_q;

  always_comb begin
    case (an_q)
      4'b1110: nibble = shown[3:0];
      4'b1101: nibble = shown[7:4];
      4'b1011: nibble = shown[11:8];
      4'b0111: nibble = shown[15:12];
      default: nibble = 4'h0;
    endcase
  end

  // ---------------------------------------------------------------- owner decode
  always_comb begin
    case (owner)
      2'd0:    begin own_oh = 3'b001; own_data = data0; end
      2'd1:    begin own_oh = 3'b010; own_data = data1; end
      default: begin own_oh = 3'b100; own_data = data2; end
    endcase
  end

  assign any_req   = |req;
  assign owner_req = |(req & own_oh);
  assign other_req = |(req & ~own_oh);

  // Round-robin: search starts just after the previous owner and ends on it,
  // so a sole requester can win again.
  always_comb begin
    pick = owner;
    case (owner)
      2'd0: begin
        if      (req[1]) pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if      (req[2]) pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if      (req[0]) pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = OWN;
          take      = 1'b1;
        end
      end
      OWN: begin
        // A dropped owner leaves at once; pre-emption only at a frame boundary.
        if (!owner_req)
          state_nxt = SWITCH;
        else if (frame_tick && (hold_cnt == HOLD_MAX) && other_req)
          state_nxt = SWITCH;
      end
      SWITCH: begin
        if (frame_tick) begin
          if (any_req) begin
            state_nxt = OWN;
            take      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // owner doubles as last_owner; reset to 2 so the first pick favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 2'd2;
      hold_cnt <= 8'd0;
      shown    <= 16'h0000;
    end else begin
      if (take) begin
        owner    <= pick;
        hold_cnt <= 8'd0;
      end else if (state == OWN && frame_tick && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
      if (state == OWN) shown <= own_data;
    end
  end

  assign grant = (state == OWN) ? own_oh : 3'b000;
  assign blank = (state != OWN);

endmodule
